param_shift_deser_reg: RTL and testbench

Parameterized serial-to-parallel receive register that reassembles words emitted bit-by-bit by the team's parallel-load/direction shift register. It supports MSB-first or LSB-first framing with an active-low bit-enable, and runs a bit counter with a two-state FSM. Completed words go to a holding register with a valid/ack handshake and sticky overrun detection. It sits at the receiving end of a serial link, between the serial pin/pipe and parallel consumer logic.

---
 rtl/param_shift_deser_reg.sv | 136 +++++++++++++
 tb/tb_param_shift_deser_reg.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/param_shift_deser_reg.sv
`default_nettype none
// ============================================================================
// Module   : param_shift_deser_reg
// Brief    : Serial-to-parallel receive register, MSB/LSB-first framing,
//            valid/ack output holding register with sticky overrun.
// Revision : 1.0 - initial release
// ============================================================================
module param_shift_deser_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_n,
    input  logic             ser_in,
    input  logic             direction,
    input  logic             par_ack,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] par_out_q, par_out_d;
    logic             par_valid_q, par_valid_d;
    logic             overrun_q, overrun_d;

    logic             frame_dir;
    logic [WIDTH-1:0] shifted;
    logic             complete;

    // The first bit of a frame uses the live direction input; later bits the latched one.
    assign frame_dir = (state_q == IDLE) ? direction : dir_q;

    generate
        if (WIDTH == 1) begin : g_width_one
            assign shifted = ser_in;
        end else begin : g_width_multi
            assign shifted = frame_dir ? {shreg_q[WIDTH-2:0], ser_in}
                                       : {ser_in, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        complete = 1'b0;

        if (!en_n) begin
            shreg_d = shifted;
            case (state_q)
                IDLE: begin
                    dir_d = direction;
                    if (WIDTH == 1) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q == LAST_CNT) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output holding register: an ack in the completion cycle frees the slot for the new word.
    always_comb begin
        par_out_d   = par_out_q;
        par_valid_d = par_valid_q;
        overrun_d   = overrun_q;

        if (complete) begin
            if (!par_valid_q || par_ack) begin
                par_out_d   = shifted;
                par_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (par_ack && par_valid_q) begin
            par_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            par_out_q   <= '0;
            par_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            par_out_q   <= par_out_d;
            par_valid_q <= par_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign par_out   = par_out_q;
    assign par_valid = par_valid_q;
    assign busy      = (state_q == SHIFT);
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_param_shift_deser_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_shift_deser_reg
// Brief    : Directed self-checking bench for param_shift_deser_reg (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_shift_deser_reg;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             en_n;
    logic             ser_in;
    logic             direction;
    logic             par_ack;
    logic [WIDTH-1:0] par_out;
    logic             par_valid;
    logic             busy;
    logic             overrun;

    int n_checks;
    int n_errors;

    param_shift_deser_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_n      (en_n),
        .ser_in    (ser_in),
        .direction (direction),
        .par_ack   (par_ack),
        .par_out   (par_out),
        .par_valid (par_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at negedge; one call advances through one posedge to the next negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic d, input logic ack);
        en_n      = 1'b0;
        ser_in    = b;
        direction = d;
        par_ack   = ack;
        step();
        en_n    = 1'b1;
        par_ack = 1'b0;
    endtask

    // bits[3] is sent first
    task automatic send_word(input logic [3:0] bits, input logic d);
        for (int i = 3; i >= 0; i--) send_bit(bits[i], d, 1'b0);
    endtask

    task automatic ack_once();
        par_ack = 1'b1;
        step();
        par_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        en_n      = 1'b0;
        ser_in    = 1'b0;
        direction = 1'b1;
        par_ack   = 1'b0;

        // Reset held with bits being offered
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            ser_in = ~ser_in;
            step();
            check("rst_par_out", 32'(par_out), 32'h0);
            check("rst_flags", {29'b0, par_valid, busy, overrun}, 32'h0);
        end
        en_n  = 1'b1;
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_par_out", 32'(par_out), 32'h0);
        check("post_rst_flags", {29'b0, par_valid, busy, overrun}, 32'h0);

        // MSB-first 1,0,1,1
        send_bit(1'b1, 1'b1, 1'b0);
        check("msb_busy_b1", 32'(busy), 32'h1);
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        check("msb_valid_b3", 32'(par_valid), 32'h0);
        send_bit(1'b1, 1'b1, 1'b0);
        check("msb_par_out", 32'(par_out), 32'hB);
        check("msb_valid", 32'(par_valid), 32'h1);
        check("msb_busy_done", 32'(busy), 32'h0);
        ack_once();
        check("msb_ack_valid", 32'(par_valid), 32'h0);
        check("msb_ack_par_out", 32'(par_out), 32'hB);

        // LSB-first 1,0,0,0 -> 0001
        send_word(4'b1000, 1'b0);
        check("lsb_1000", 32'(par_out), 32'h1);
        check("lsb_valid", 32'(par_valid), 32'h1);
        ack_once();

        // LSB-first 1,1,1,1
        send_word(4'b1111, 1'b0);
        check("lsb_1111", 32'(par_out), 32'hF);
        ack_once();

        // LSB-first 1,0,0,0 with direction flipping mid-frame
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        check("lsb_dir_toggle", 32'(par_out), 32'h1);
        ack_once();

        // MSB-first 1,0,1,1 with a two-cycle pause after bit 2
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        step();
        check("pause_busy1", 32'(busy), 32'h1);
        step();
        check("pause_busy2", 32'(busy), 32'h1);
        check("pause_valid", 32'(par_valid), 32'h0);
        send_bit(1'b1, 1'b1, 1'b0);
        check("pause_valid_b3", 32'(par_valid), 32'h0);
        send_bit(1'b1, 1'b1, 1'b0);
        check("pause_par_out", 32'(par_out), 32'hB);
        check("pause_valid_done", 32'(par_valid), 32'h1);
        ack_once();

        // Backpressure: second word dropped
        send_word(4'b1100, 1'b1);
        check("bp_first", 32'(par_out), 32'hC);
        check("bp_no_overrun_yet", 32'(overrun), 32'h0);
        send_word(4'b0011, 1'b1);
        check("bp_kept", 32'(par_out), 32'hC);
        check("bp_overrun", 32'(overrun), 32'h1);
        check("bp_valid", 32'(par_valid), 32'h1);
        ack_once();
        check("bp_overrun_sticky", {30'b0, par_valid, overrun}, 32'h1);

        // Backpressure relieved by ack in the completion cycle
        do_reset();
        check("bp2_reset_overrun", 32'(overrun), 32'h0);
        send_word(4'b1100, 1'b1);
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b1);
        check("bp2_par_out", 32'(par_out), 32'h3);
        check("bp2_flags", {30'b0, par_valid, overrun}, 32'h2);
        ack_once();

        // Reset mid-frame, then a clean frame
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_async_busy", 32'(busy), 32'h0);
        step();
        check("midrst_flags", {29'b0, par_valid, busy, overrun}, 32'h0);
        rst_n = 1'b1;
        step();
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        check("midrst_valid_b3", 32'(par_valid), 32'h0);
        send_bit(1'b0, 1'b1, 1'b0);
        check("midrst_par_out", 32'(par_out), 32'h6);
        check("midrst_valid", 32'(par_valid), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
